alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational 16-bit alu between two requesters (0: execute path, 1: branch/compare unit).
//  Arbitrates requests, registers the winning operands/cmd into the alu inputs, and captures RES/ovF/eq_bit one cycle later.
//  Returns results tagged to the originating requester, with per-requester valid/ready backpressure.
//  Sits between the requesters and the alu instance; the alu itself is unchanged.
// PARAMETERS
//  DW    16  operand/result width; must match the alu
//  CMDW  3   alu command width (000 add, 001 sub, 010 shl, ...); passed through, never decoded
// PORTS
//  clk         in   1     system clock, rising edge
//  rst_n       in   1     asynchronous active-low reset
//  req_valid   in   2     per-requester request valid; bit i = requester i
//  req_ready   out  2     per-requester accept; handshake completes on valid&ready
//  req_op1     in   2*DW  operand 1; [DW-1:0] req0, [2DW-1:DW] req1
//  req_op2     in   2*DW  operand 2, same packing
//  req_cmd     in   2*CMDW alu cmd, same packing
//  alu_op1     out  DW    to alu OP1 (registered)
//  alu_op2     out  DW    to alu OP2 (registered)
//  alu_cmd     out  CMDW  to alu cmd (registered)
//  alu_res     in   DW    from alu RES
//  alu_ovf     in   1     from alu ovF
//  alu_eq      in   1     from alu eq_bit
//  rsp_valid   out  2     result valid for requester i
//  rsp_ready   in   2     requester i accepts the result
//  rsp_res     out  DW    result (shared bus, qualified by rsp_valid)
//  rsp_ovf     out  1     captured ovF
//  rsp_eq      out  1     captured eq_bit
// BEHAVIOUR
//  Two-stage pipeline: ISSUE (iss_vld, iss_id, alu_op1/op2/cmd regs), RESP (rsp_vld, rsp_id, res/ovf/eq regs).
//  Reset: all outputs and regs 0; iss_vld=rsp_vld=0; rr pointer=0 (req0 preferred first).
//  adv = !rsp_vld | rsp_ready[rsp_id]. RESP loads from ISSUE when adv; ISSUE loads new grant when adv (or !iss_vld).
//  req_ready = one-hot grant & {2{issue_can_load}}; issue_can_load = !iss_vld | adv. At most one bit high.
//  Grant computed combinationally from req_valid each cycle; never depends on req_ready (no comb loop).
//  Latency: accept at edge N -> alu inputs valid after N -> result captured at N+1 -> rsp_valid high from N+1. Throughput 1/cycle.
//  rsp_valid[i] = rsp_vld & (rsp_id==i). rsp_res/ovf/eq hold stable while rsp_valid & !rsp_ready.
//  Backpressure on rsp stalls both stages; alu inputs remain frozen, so alu outputs stay consistent.
//  Simultaneous response drain and new accept in the same cycle is legal; no bubble.
//  No arithmetic here: widths pass straight through; ovF/eq_bit latched exactly as the alu drives them.
//  ISSUE regs hold last operands when idle (iss_vld=0); alu outputs in that case are ignored.
//  Asynchronous reset mid-operation: in-flight requests dropped, no rsp issued; requesters must re-request.
//  Requester must hold req_* stable while req_valid & !req_ready.
// CONFIGURATION
//  ALU_ARB_RR_EN defined: round-robin; after granting i, pointer moves to 1-i; both requesting alternates 0,1,0,1.
//  ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins; requester 1 served only when req_valid[0]=0.
// TESTING
//  T1 req0: op1=0x0001 op2=0x0002 cmd=000 -> rsp_valid=01 next cycle, rsp_res=0x0003, ovf=0.
//  T2 req1: op1=0x7FFF op2=0x7FFF cmd=000 -> rsp_valid=10, rsp_res=0xFFFE, ovf=1.
//  T3 both valid 4 cycles, RR_EN set -> grants 0,1,0,1; unset -> four grants to 0, req_ready[1]=0 throughout.
//  T4 req0 sub 0x8000-0xFFFF with rsp_ready=00 for 3 cycles -> rsp_res=0x8001 held stable, req_ready=00 once both stages full.
//  T5 req0 shl 0x7000 by 1, back-to-back with req1 add 10+20 -> rsp 0xE000 then 0x001E in consecutive cycles.
//  T6 rst_n low while iss_vld=1 -> rsp_valid=00, alu_op1/op2/cmd=0, no stale rsp after release.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester-side request/response bundle for alu_arbiter.
// The slave modport is the arbiter; the master modport is the pair of requesters.
interface alu_arbiter_if #(
  parameter int unsigned DW   = 16,
  parameter int unsigned CMDW = 3
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*DW-1:0]   req_op1;
  logic [2*DW-1:0]   req_op2;
  logic [2*CMDW-1:0] req_cmd;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DW-1:0]     rsp_res;
  logic              rsp_ovf;
  logic              rsp_eq;

  modport slave (
    input  req_valid, req_op1, req_op2, req_cmd, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_ovf, rsp_eq
  );

  modport master (
    output req_valid, req_op1, req_op2, req_cmd, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_ovf, rsp_eq
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: ISSUE stage drives the ALU inputs,
// RESP stage captures its outputs. Define ALU_ARB_RR_EN for round-robin, else req0 has priority.
module alu_arbiter #(
  parameter int unsigned DW   = 16,
  parameter int unsigned CMDW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_arbiter_if.slave    bus_io,
  output logic [DW-1:0]   alu_op1_o,
  output logic [DW-1:0]   alu_op2_o,
  output logic [CMDW-1:0] alu_cmd_o,
  input  logic [DW-1:0]   alu_res_i,
  input  logic            alu_ovf_i,
  input  logic            alu_eq_i
);

  logic [1:0]      gnt;
  logic            adv;
  logic            issue_can_load;
  logic [1:0]      req_ready;

  logic            iss_vld_q, iss_vld_d;
  logic            iss_id_q, iss_id_d;
  logic [DW-1:0]   op1_q, op1_d;
  logic [DW-1:0]   op2_q, op2_d;
  logic [CMDW-1:0] cmd_q, cmd_d;

  logic            rsp_vld_q, rsp_vld_d;
  logic            rsp_id_q, rsp_id_d;
  logic [DW-1:0]   res_q, res_d;
  logic            ovf_q, ovf_d;
  logic            eq_q, eq_d;

  // Grant looks only at req_valid so req_ready never feeds back into itself.
`ifdef ALU_ARB_RR_EN
  logic rr_q, rr_d;

  always_comb begin
    gnt = 2'b00;
    if (rr_q) begin
      if (bus_io.req_valid[1])      gnt = 2'b10;
      else if (bus_io.req_valid[0]) gnt = 2'b01;
    end else begin
      if (bus_io.req_valid[0])      gnt = 2'b01;
      else if (bus_io.req_valid[1]) gnt = 2'b10;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (|req_ready) rr_d = req_ready[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`else
  assign gnt = bus_io.req_valid[0] ? 2'b01 : {bus_io.req_valid[1], 1'b0};
`endif

  assign adv            = !rsp_vld_q || bus_io.rsp_ready[rsp_id_q];
  assign issue_can_load = !iss_vld_q || adv;
  assign req_ready      = gnt & {2{issue_can_load}};

  always_comb begin
    iss_vld_d = iss_vld_q;
    iss_id_d  = iss_id_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    cmd_d     = cmd_q;
    rsp_vld_d = rsp_vld_q;
    rsp_id_d  = rsp_id_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    eq_d      = eq_q;

    if (adv) begin
      rsp_vld_d = iss_vld_q;
      if (iss_vld_q) begin
        rsp_id_d = iss_id_q;
        res_d    = alu_res_i;
        ovf_d    = alu_ovf_i;
        eq_d     = alu_eq_i;
      end
    end

    // Operands are left in place when idle; the ALU result is simply not captured.
    if (issue_can_load) begin
      iss_vld_d = |gnt;
      if (|gnt) begin
        iss_id_d = gnt[1];
        if (gnt[1]) begin
          op1_d = bus_io.req_op1[2*DW-1:DW];
          op2_d = bus_io.req_op2[2*DW-1:DW];
          cmd_d = bus_io.req_cmd[2*CMDW-1:CMDW];
        end else begin
          op1_d = bus_io.req_op1[DW-1:0];
          op2_d = bus_io.req_op2[DW-1:0];
          cmd_d = bus_io.req_cmd[CMDW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld_q <= 1'b0;
      iss_id_q  <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      cmd_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      iss_vld_q <= iss_vld_d;
      iss_id_q  <= iss_id_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      cmd_q     <= cmd_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      eq_q      <= eq_d;
    end
  end

  assign bus_io.req_ready = req_ready;
  assign bus_io.rsp_valid = {rsp_vld_q & rsp_id_q, rsp_vld_q & ~rsp_id_q};
  assign bus_io.rsp_res   = res_q;
  assign bus_io.rsp_ovf   = ovf_q;
  assign bus_io.rsp_eq    = eq_q;

  assign alu_op1_o = op1_q;
  assign alu_op2_o = op2_q;
  assign alu_cmd_o = cmd_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small reference ALU (add/sub/shl) on the ALU side.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] alu_op1, alu_op2, alu_res;
  logic [2:0]  alu_cmd;
  logic        alu_ovf, alu_eq;
  int          n_cmp;
  int          n_err;

  alu_arbiter_if #(.DW(16), .CMDW(3)) bus ();

  alu_arbiter #(.DW(16), .CMDW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_io    (bus),
    .alu_op1_o (alu_op1),
    .alu_op2_o (alu_op2),
    .alu_cmd_o (alu_cmd),
    .alu_res_i (alu_res),
    .alu_ovf_i (alu_ovf),
    .alu_eq_i  (alu_eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the real ALU: signed overflow on add/sub, eq_bit = (op1 == op2).
  always_comb begin
    alu_res = 16'h0000;
    alu_ovf = 1'b0;
    case (alu_cmd)
      3'd0: begin
        alu_res = alu_op1 + alu_op2;
        alu_ovf = (alu_op1[15] == alu_op2[15]) && (alu_res[15] != alu_op1[15]);
      end
      3'd1: begin
        alu_res = alu_op1 - alu_op2;
        alu_ovf = (alu_op1[15] != alu_op2[15]) && (alu_res[15] != alu_op1[15]);
      end
      3'd2: alu_res = alu_op1 << alu_op2[3:0];
      default: alu_res = 16'h0000;
    endcase
    alu_eq = (alu_op1 == alu_op2);
  end

  typedef struct {
    logic        id;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [2:0]  cmd;
    logic [15:0] res;
    logic        ovf;
    logic        eq;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] c);
    if (id) begin
      bus.req_op1[31:16] = a;
      bus.req_op2[31:16] = b;
      bus.req_cmd[5:3]   = c;
      bus.req_valid[1]   = 1'b1;
    end else begin
      bus.req_op1[15:0] = a;
      bus.req_op2[15:0] = b;
      bus.req_cmd[2:0]  = c;
      bus.req_valid[0]  = 1'b1;
    end
  endtask

  task automatic do_reset();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    oh = v.id ? 2'b10 : 2'b01;
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b00;
    set_req(v.id, v.op1, v.op2, v.cmd);
    #1;
    chk("vec_req_ready", {30'd0, bus.req_ready}, {30'd0, oh});
    step();
    bus.req_valid = 2'b00;
    chk("vec_alu_op1", {16'd0, alu_op1}, {16'd0, v.op1});
    chk("vec_alu_cmd", {29'd0, alu_cmd}, {29'd0, v.cmd});
    chk("vec_rsp_early", {30'd0, bus.rsp_valid}, 32'd0);
    step();
    chk("vec_rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, oh});
    chk("vec_rsp_res", {16'd0, bus.rsp_res}, {16'd0, v.res});
    chk("vec_rsp_ovf", {31'd0, bus.rsp_ovf}, {31'd0, v.ovf});
    chk("vec_rsp_eq", {31'd0, bus.rsp_eq}, {31'd0, v.eq});
    step();
    chk("vec_rsp_drained", {30'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation ran past time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] arb_exp [4];
    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{id: 1'b0, op1: 16'h0001, op2: 16'h0002, cmd: 3'd0, res: 16'h0003, ovf: 1'b0,
                eq: 1'b0};
    vecs[1] = '{id: 1'b1, op1: 16'h7FFF, op2: 16'h7FFF, cmd: 3'd0, res: 16'hFFFE, ovf: 1'b1,
                eq: 1'b1};
    vecs[2] = '{id: 1'b0, op1: 16'h0005, op2: 16'h0005, cmd: 3'd1, res: 16'h0000, ovf: 1'b0,
                eq: 1'b1};
    vecs[3] = '{id: 1'b1, op1: 16'h0001, op2: 16'h0004, cmd: 3'd2, res: 16'h0010, ovf: 1'b0,
                eq: 1'b0};
    vecs[4] = '{id: 1'b0, op1: 16'h0000, op2: 16'h0001, cmd: 3'd1, res: 16'hFFFF, ovf: 1'b0,
                eq: 1'b0};
    vecs[5] = '{id: 1'b1, op1: 16'h8000, op2: 16'h8000, cmd: 3'd0, res: 16'h0000, ovf: 1'b1,
                eq: 1'b1};
`ifdef ALU_ARB_RR_EN
    arb_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    arb_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.req_cmd   = '0;
    bus.rsp_ready = 2'b00;
    #2;
    chk("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("rst_alu_op1", {16'd0, alu_op1}, 32'd0);
    chk("rst_rsp_res", {16'd0, bus.rsp_res}, 32'd0);
    do_reset();

    // Single transactions, one at a time through an empty pipeline.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Both requesters held valid for four cycles.
    do_reset();
    set_req(1'b0, 16'h0001, 16'h0001, 3'd0);
    set_req(1'b1, 16'h0002, 16'h0002, 3'd0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("arb_req_ready", {30'd0, bus.req_ready}, {30'd0, arb_exp[c]});
      if (c >= 2) chk("arb_rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, arb_exp[c-2]});
      step();
    end
    bus.req_valid = 2'b00;
    chk("arb_rsp_tail2", {30'd0, bus.rsp_valid}, {30'd0, arb_exp[2]});
    step();
    chk("arb_rsp_tail3", {30'd0, bus.rsp_valid}, {30'd0, arb_exp[3]});
    step();
    chk("arb_rsp_empty", {30'd0, bus.rsp_valid}, 32'd0);

    // Response backpressure fills both stages and freezes them.
    do_reset();
    bus.rsp_ready = 2'b00;
    set_req(1'b0, 16'h8000, 16'hFFFF, 3'd1);
    #1;
    chk("bp_ready0", {30'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 2'b00;
    set_req(1'b1, 16'h000A, 16'h0014, 3'd0);
    #1;
    chk("bp_ready1", {30'd0, bus.req_ready}, 32'd2);
    step();
    bus.req_valid = 2'b00;
    set_req(1'b0, 16'h0003, 16'h0004, 3'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_req_stalled", {30'd0, bus.req_ready}, 32'd0);
      chk("bp_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
      chk("bp_rsp_res", {16'd0, bus.rsp_res}, 32'h8001);
      chk("bp_alu_frozen", {16'd0, alu_op1}, 32'h000A);
      step();
    end
    bus.rsp_ready = 2'b11;
    #1;
    chk("bp_release_ready", {30'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 2'b00;
    chk("bp_rsp1_valid", {30'd0, bus.rsp_valid}, 32'd2);
    chk("bp_rsp1_res", {16'd0, bus.rsp_res}, 32'h001E);
    step();
    chk("bp_rsp0_valid", {30'd0, bus.rsp_valid}, 32'd1);
    chk("bp_rsp0_res", {16'd0, bus.rsp_res}, 32'h0007);
    step();
    chk("bp_empty", {30'd0, bus.rsp_valid}, 32'd0);

    // Back-to-back accepts from different requesters, no bubble.
    do_reset();
    set_req(1'b0, 16'h7000, 16'h0001, 3'd2);
    #1;
    chk("b2b_ready0", {30'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 2'b00;
    set_req(1'b1, 16'h000A, 16'h0014, 3'd0);
    #1;
    chk("b2b_ready1", {30'd0, bus.req_ready}, 32'd2);
    step();
    bus.req_valid = 2'b00;
    chk("b2b_rsp0_valid", {30'd0, bus.rsp_valid}, 32'd1);
    chk("b2b_rsp0_res", {16'd0, bus.rsp_res}, 32'hE000);
    step();
    chk("b2b_rsp1_valid", {30'd0, bus.rsp_valid}, 32'd2);
    chk("b2b_rsp1_res", {16'd0, bus.rsp_res}, 32'h001E);
    step();
    chk("b2b_empty", {30'd0, bus.rsp_valid}, 32'd0);

    // Asynchronous reset with a request sitting in ISSUE.
    do_reset();
    set_req(1'b0, 16'h1234, 16'h1111, 3'd1);
    step();
    bus.req_valid = 2'b00;
    chk("rst6_issued", {16'd0, alu_op1}, 32'h1234);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst6_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("rst6_alu_op1", {16'd0, alu_op1}, 32'd0);
    chk("rst6_alu_op2", {16'd0, alu_op2}, 32'd0);
    chk("rst6_alu_cmd", {29'd0, alu_cmd}, 32'd0);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst6_no_stale", {30'd0, bus.rsp_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
